// File: rtl/mul_sequencer.sv
// mul_sequencer
//   Issue/writeback controller for the NEANDER-X MUL instruction. Sits between
//   the CPU control unit and the 16-cycle shift-and-add sequential_multiplier:
//   latches the operands (as magnitudes for signed operations), launches the
//   multiplier, waits for its done pulse, restores the sign and presents the
//   32-bit product with Z/N/V flags while stalling the CPU.
//
// Optional feature: define SIGNED_MUL_EN to build the signed path (operand
//   magnitude conversion, product negation and the signed overflow rule).
//   Without it signed_op is ignored and every operation is unsigned; FIXUP
//   remains as a pass-through state so the latency does not change.
//
// Parameters
//   WDOG_CYCLES   WAIT-state cycles allowed before the watchdog aborts
// Ports
//   clk, reset          clock; asynchronous active-high reset
//   req                 multiply request, sampled only in IDLE
//   signed_op           1 = two's-complement operands
//   op_a, op_b          multiplicand (AC) / multiplier (memory operand)
//   busy                stall to the control unit (state != IDLE)
//   result_valid        one-cycle pulse in WRITE
//   ac_out, y_out       product bits 15:0 / 31:16 (held between operations)
//   flag_z/n/v          zero, negative, does-not-fit-in-16-bits
//   err                 watchdog abort, sticky until the next accepted req
//   mul_start           one-cycle start pulse to the multiplier
//   mul_a, mul_b        operands to the multiplier, stable LAUNCH..WAIT
//   mul_done            done pulse from the multiplier
//   mul_lo, mul_hi      multiplier product low/high words
module mul_sequencer #(
  parameter int WDOG_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        signed_op,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  output logic        busy,
  output logic        result_valid,
  output logic [15:0] ac_out,
  output logic [15:0] y_out,
  output logic        flag_z,
  output logic        flag_n,
  output logic        flag_v,
  output logic        err,
  output logic        mul_start,
  output logic [15:0] mul_a,
  output logic [15:0] mul_b,
  input  logic        mul_done,
  input  logic [15:0] mul_lo,
  input  logic [15:0] mul_hi
);

  localparam int WDW = $clog2(WDOG_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_FIXUP,
    S_WRITE
  } state_e;

  state_e      state_q, state_d;
  logic [WDW-1:0] wdog_q, wdog_d;
  logic [15:0] mag_a_q, mag_a_d;
  logic [15:0] mag_b_q, mag_b_d;
  logic        neg_q, neg_d;
  logic [31:0] prod_q, prod_d;
  logic [15:0] ac_q, ac_d;
  logic [15:0] y_q, y_d;
  logic        z_q, z_d;
  logic        n_q, n_d;
  logic        v_q, v_d;
  logic        err_q, err_d;

  // Operand conditioning at request time.
  logic [15:0] in_mag_a, in_mag_b;
  logic        in_neg;
  logic        v_rule;

`ifdef SIGNED_MUL_EN
  logic sgn_q, sgn_d;

  // |0x8000| wraps back to 0x8000, which is the correct unsigned magnitude.
  assign in_mag_a = (signed_op && op_a[15]) ? (~op_a + 16'd1) : op_a;
  assign in_mag_b = (signed_op && op_b[15]) ? (~op_b + 16'd1) : op_b;
  assign in_neg   = signed_op & (op_a[15] ^ op_b[15]);
  // Signed result fits in 16 bits only if the high word is the sign extension.
  assign v_rule   = sgn_q ? (prod_q[31:16] != {16{prod_q[15]}})
                          : (prod_q[31:16] != 16'd0);
`else
  logic unused_signed_op;

  assign unused_signed_op = signed_op;
  assign in_mag_a = op_a;
  assign in_mag_b = op_b;
  assign in_neg   = 1'b0;
  assign v_rule   = (prod_q[31:16] != 16'd0);
`endif

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d = state_q;
    wdog_d  = wdog_q;
    mag_a_d = mag_a_q;
    mag_b_d = mag_b_q;
    neg_d   = neg_q;
    prod_d  = prod_q;
    ac_d    = ac_q;
    y_d     = y_q;
    z_d     = z_q;
    n_d     = n_q;
    v_d     = v_q;
    err_d   = err_q;
`ifdef SIGNED_MUL_EN
    sgn_d   = sgn_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_LAUNCH;
          mag_a_d = in_mag_a;
          mag_b_d = in_mag_b;
          neg_d   = in_neg;
          err_d   = 1'b0;
          wdog_d  = '0;
`ifdef SIGNED_MUL_EN
          sgn_d   = signed_op;
`endif
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT;
        wdog_d  = '0;
      end
      S_WAIT: begin
        // A done pulse on the last allowed cycle still wins over the abort.
        if (mul_done) begin
          prod_d  = {mul_hi, mul_lo};
          state_d = S_FIXUP;
          wdog_d  = '0;
        end else if (wdog_q == WDW'(WDOG_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
          wdog_d  = '0;
        end else begin
          wdog_d  = wdog_q + WDW'(1);
        end
      end
      S_FIXUP: begin
`ifdef SIGNED_MUL_EN
        if (neg_q) prod_d = ~prod_q + 32'd1;
`endif
        state_d = S_WRITE;
      end
      S_WRITE: begin
        ac_d    = prod_q[15:0];
        y_d     = prod_q[31:16];
        z_d     = (prod_q == 32'd0);
        n_d     = prod_q[31];
        v_d     = v_rule;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      wdog_q  <= '0;
      mag_a_q <= '0;
      mag_b_q <= '0;
      neg_q   <= 1'b0;
      prod_q  <= '0;
      ac_q    <= '0;
      y_q     <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
      err_q   <= 1'b0;
`ifdef SIGNED_MUL_EN
      sgn_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wdog_q  <= wdog_d;
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      neg_q   <= neg_d;
      prod_q  <= prod_d;
      ac_q    <= ac_d;
      y_q     <= y_d;
      z_q     <= z_d;
      n_q     <= n_d;
      v_q     <= v_d;
      err_q   <= err_d;
`ifdef SIGNED_MUL_EN
      sgn_q   <= sgn_d;
`endif
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign result_valid = (state_q == S_WRITE);
  assign mul_start    = (state_q == S_LAUNCH);
  assign mul_a        = mag_a_q;
  assign mul_b        = mag_b_q;
  assign ac_out       = ac_q;
  assign y_out        = y_q;
  assign flag_z       = z_q;
  assign flag_n       = n_q;
  assign flag_v       = v_q;
  assign err          = err_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer
//   Directed, table-driven bench for mul_sequencer. A small behavioural model
//   of the 16-cycle multiplier answers mul_start with mul_done 17 cycles later
//   (or never, when stub_dead is set). Expected values are hand-computed
//   constants; the signed-dependent rows follow SIGNED_MUL_EN.
module tb_mul_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        signed_op;
  logic [15:0] op_a, op_b;
  logic        busy, result_valid;
  logic [15:0] ac_out, y_out;
  logic        flag_z, flag_n, flag_v, err;
  logic        mul_start;
  logic [15:0] mul_a, mul_b;
  logic        mul_done;
  logic [15:0] mul_lo, mul_hi;

  int checks = 0;
  int errors = 0;
  bit stub_dead = 1'b0;

  always #5 clk = ~clk;

  mul_sequencer #(.WDOG_CYCLES(32)) dut (
    .clk(clk), .reset(reset), .req(req), .signed_op(signed_op),
    .op_a(op_a), .op_b(op_b), .busy(busy), .result_valid(result_valid),
    .ac_out(ac_out), .y_out(y_out), .flag_z(flag_z), .flag_n(flag_n),
    .flag_v(flag_v), .err(err), .mul_start(mul_start), .mul_a(mul_a),
    .mul_b(mul_b), .mul_done(mul_done), .mul_lo(mul_lo), .mul_hi(mul_hi)
  );

  // Multiplier model: start sampled at the end of cycle 1, done high in cycle 18.
  logic [4:0] mcnt;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mcnt <= '0; mul_done <= 1'b0; mul_lo <= '0; mul_hi <= '0;
    end else begin
      mul_done <= 1'b0;
      if (mul_start) begin
        mcnt <= 5'd16;
        {mul_hi, mul_lo} <= 32'(mul_a) * 32'(mul_b);
      end else if (mcnt != 0) begin
        mcnt <= mcnt - 5'd1;
        if (mcnt == 5'd1 && !stub_dead) mul_done <= 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Issues one request at cycle 0 and runs until result_valid (or timeout),
  // then steps to the cycle after WRITE. Optional extra req pulses at 5 and 20.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                        input bit extra_req, output int lat, output logic [15:0] ma,
                        output logic [15:0] mb, output int busy_bad, output int starts);
    @(posedge clk); #1;
    req = 1'b1; op_a = a; op_b = b; signed_op = s;
    lat = -1; busy_bad = 0; starts = 0; ma = '0; mb = '0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      req = extra_req && (c == 5 || c == 20);
      if (c == 1) begin ma = mul_a; mb = mul_b; end
      if (mul_start) starts++;
      if (!busy) busy_bad++;
      if (result_valid) begin lat = c; break; end
    end
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  typedef struct {
    logic [15:0] a, b;
    logic        s;
    logic [15:0] ma, mb, ac, y;
    logic [2:0]  znv;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int lat, busy_bad, starts, fall, rv;
    logic [15:0] ma, mb;

    vecs[0] = '{16'h1234, 16'h5678, 1'b0, 16'h1234, 16'h5678, 16'h0060, 16'h0626, 3'b001};
`ifdef SIGNED_MUL_EN
    vecs[1] = '{16'hFFFD, 16'h0005, 1'b1, 16'h0003, 16'h0005, 16'hFFF1, 16'hFFFF, 3'b010};
    vecs[5] = '{16'h0007, 16'hFFFE, 1'b1, 16'h0007, 16'h0002, 16'hFFF2, 16'hFFFF, 3'b010};
    vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'h0001, 16'h0001, 16'h0001, 16'h0000, 3'b000};
    vecs[8] = '{16'h0100, 16'h0080, 1'b1, 16'h0100, 16'h0080, 16'h8000, 16'h0000, 3'b001};
`else
    vecs[1] = '{16'hFFFD, 16'h0005, 1'b1, 16'hFFFD, 16'h0005, 16'hFFF1, 16'h0004, 3'b001};
    vecs[5] = '{16'h0007, 16'hFFFE, 1'b1, 16'h0007, 16'hFFFE, 16'hFFF2, 16'h0006, 3'b001};
    vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 3'b011};
    vecs[8] = '{16'h0100, 16'h0080, 1'b1, 16'h0100, 16'h0080, 16'h8000, 16'h0000, 3'b000};
`endif
    vecs[2] = '{16'h8000, 16'h8000, 1'b1, 16'h8000, 16'h8000, 16'h0000, 16'h4000, 3'b001};
    vecs[3] = '{16'h0000, 16'h7FFF, 1'b0, 16'h0000, 16'h7FFF, 16'h0000, 16'h0000, 3'b100};
    vecs[4] = '{16'h0003, 16'h0004, 1'b0, 16'h0003, 16'h0004, 16'h000C, 16'h0000, 3'b000};
    vecs[7] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 3'b011};

    reset = 1'b1; req = 1'b0; signed_op = 1'b0; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ctrl", {busy, result_valid, mul_start, err}, 0);
    check("reset_data", {ac_out, y_out}, 0);
    check("reset_flags", {flag_z, flag_n, flag_v}, 0);
    check("reset_mul_ops", {mul_a, mul_b}, 0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, 1'b0, lat, ma, mb, busy_bad, starts);
      check($sformatf("v%0d_latency", i), lat, 20);
      check($sformatf("v%0d_mul_ab", i), {ma, mb}, {vecs[i].ma, vecs[i].mb});
      check($sformatf("v%0d_busy_gaps", i), busy_bad, 0);
      check($sformatf("v%0d_starts", i), starts, 1);
      check($sformatf("v%0d_product", i), {y_out, ac_out}, {vecs[i].y, vecs[i].ac});
      check($sformatf("v%0d_znv", i), {flag_z, flag_n, flag_v}, vecs[i].znv);
      check($sformatf("v%0d_idle_after", i), {busy, result_valid, err}, 0);
    end

    // Watchdog: multiplier never answers.
    stub_dead = 1'b1;
    @(posedge clk); #1;
    req = 1'b1; op_a = 16'h0011; op_b = 16'h0011; signed_op = 1'b0;
    fall = -1; rv = 0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      req = 1'b0;
      if (result_valid) rv++;
      if (c == 33) check("wdog_c33_busy_err", {busy, err}, 2'b10);
      if (!busy) begin fall = c; break; end
    end
    check("wdog_fall_cycle", fall, 34);
    check("wdog_err", err, 1);
    check("wdog_no_valid", rv, 0);
    check("wdog_outputs_held", {y_out, ac_out}, {vecs[8].y, vecs[8].ac});
    check("wdog_flags_held", {flag_z, flag_n, flag_v}, vecs[8].znv);
    stub_dead = 1'b0;
    repeat (20) @(posedge clk);
    #1;

    // Zero product with stray requests at cycles 5 and 20; also clears err.
    run_op(16'h0000, 16'h7FFF, 1'b0, 1'b1, lat, ma, mb, busy_bad, starts);
    check("seqA_latency", lat, 20);
    check("seqA_busy_gaps", busy_bad, 0);
    check("seqA_starts", starts, 1);
    check("seqA_product", {y_out, ac_out}, 0);
    check("seqA_znv", {flag_z, flag_n, flag_v}, 3'b100);
    check("seqA_err_cleared", err, 0);
    check("seqA_c21_idle", {busy, mul_start}, 0);
    @(posedge clk); #1;
    check("seqA_c22_idle", {busy, mul_start}, 0);

    // Reset in the middle of an operation (cycle 10).
    @(posedge clk); #1;
    req = 1'b1; op_a = 16'h1234; op_b = 16'h5678; signed_op = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      req = 1'b0;
    end
    check("seqC_busy_before", busy, 1);
    reset = 1'b1;
    #1;
    check("seqC_reset_ctrl", {busy, result_valid, mul_start, err}, 0);
    check("seqC_reset_data", {y_out, ac_out, mul_a, mul_b}, 0);
    check("seqC_reset_flags", {flag_z, flag_n, flag_v}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    rv = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (result_valid || busy || mul_start) rv++;
    end
    check("seqC_quiet_after", rv, 0);
    run_op(16'h0003, 16'h0004, 1'b0, 1'b0, lat, ma, mb, busy_bad, starts);
    check("seqC_fresh_latency", lat, 20);
    check("seqC_fresh_product", {y_out, ac_out}, 32'h0000000C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Issue-and-writeback controller for the NEANDER-X MUL instruction, placed between the CPU control unit and the 16-cycle shift-and-add `sequential_multiplier`. On a request it latches the operands and converts signed operands to magnitudes. It then launches the multiplier and waits for its done pulse. Finally it restores the sign and presents the 32-bit product (low word to AC, high word to Y) with Z/N/overflow flags, holding the CPU in a stall for the whole operation.

## Interface
Parameters:
- WDOG_CYCLES, 32: maximum WAIT-state cycles before the watchdog aborts.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- req  in  1  multiply request from the control unit; sampled only in IDLE
- signed_op  in  1  1 = two's-complement operands; 0 = unsigned
- op_a  in  16  multiplicand (AC)
- op_b  in  16  multiplier (memory operand)
- busy  out  1  stall to the control unit; high whenever state != IDLE
- result_valid  out  1  one-cycle pulse in WRITE
- ac_out  out  16  product bits 15:0
- y_out  out  16  product bits 31:16
- flag_z  out  1  32-bit product == 0
- flag_n  out  1  product bit 31
- flag_v  out  1  product does not fit in 16 bits
- err  out  1  watchdog abort; sticky until the next accepted req
- mul_start  out  1  start pulse to the multiplier
- mul_a  out  16  multiplicand to the multiplier
- mul_b  out  16  multiplier operand to the multiplier
- mul_done  in  1  done pulse from the multiplier
- mul_lo  in  16  multiplier product_low
- mul_hi  in  16  multiplier product_high

## Operation
- States: IDLE, LAUNCH, WAIT, FIXUP, WRITE.
- IDLE → LAUNCH on req.
  - Latch mag_a, mag_b: |op_a| and |op_b| when signed_op = 1, otherwise raw values. |0x8000| = 0x8000.
  - Latch neg = signed_op & (op_a[15] ^ op_b[15]).
  - Clear err.
- LAUNCH: mul_start = 1 for exactly this cycle; mul_a = mag_a and mul_b = mag_b, held stable from LAUNCH through WAIT. Always → WAIT.
- WAIT: on mul_done, capture {mul_hi, mul_lo} into a 32-bit product register, then → FIXUP. The watchdog counts WAIT cycles; when it reaches WDOG_CYCLES without mul_done, set err = 1 and go → IDLE with no WRITE and outputs unchanged.
- FIXUP: when neg = 1, replace the product with its 32-bit two's complement (~P + 1). FIXUP is always traversed. → WRITE.
- WRITE:
  - result_valid = 1.
  - Update ac_out and y_out, plus flag_z, flag_n and flag_v.
  - Unsigned: flag_v = (P[31:16] != 0).
  - Signed: flag_v = (P[31:16] != {16{P[15]}}).
  - → IDLE.
- Outputs hold their last WRITE values between operations.
- req outside IDLE is ignored; it is not queued.
- req asserted during the WRITE cycle is not accepted. It is accepted if still high in the following IDLE cycle.
- mul_done outside WAIT is ignored.

## Timing
- Reset values: all outputs 0. State = IDLE, watchdog = 0, product register = 0.
- Reset mid-operation returns to IDLE at once, with no result_valid and no mul_start. Both blocks share reset, so the multiplier aborts too.
- Cycle 0: req sampled in IDLE.
- Cycle 1: LAUNCH, mul_start = 1, busy rises.
- Cycles 2-17: multiplier busy.
- Cycle 18: mul_done = 1, captured at the end of the cycle.
- Cycle 19: FIXUP.
- Cycle 20: WRITE, result_valid = 1; the new ac_out, y_out and flags are visible from cycle 21.
- busy is high on cycles 1-20. Fixed latency is 20 cycles from req to result_valid, identical for signed and unsigned operations.
- Watchdog abort: err rises on the cycle after WDOG_CYCLES consecutive WAIT cycles; busy falls on the same edge.

## Configuration
- SIGNED_MUL_EN defined:
  - signed_op is honoured.
  - Magnitude conversion, negation in FIXUP and the signed flag_v rule are compiled in.
- SIGNED_MUL_EN undefined:
  - signed_op is ignored and neg is forced to 0.
  - No abs/negate logic is built and flag_v uses the unsigned rule.
  - FIXUP remains a pass-through state, so latency stays at 20 cycles.

## Test plan
- Unsigned 0x1234 × 0x5678 → result_valid exactly 20 cycles after req; ac_out = 0x0060, y_out = 0x0626, Z = 0, N = 0, V = 1.
- Signed 0xFFFD × 0x0005 → mul_a = 0x0003, mul_b = 0x0005; ac_out = 0xFFF1, y_out = 0xFFFF, N = 1, V = 0. Without SIGNED_MUL_EN the same stimulus gives y_out:ac_out = 0x0004FFF1 and V = 1.
- Signed 0x8000 × 0x8000 → 0x40000000, V = 1, N = 0.
- Unsigned 0x0000 × 0x7FFF → 0x00000000, Z = 1. A second req pulsed at cycles 5 and 20 of this operation is ignored, and busy stays high through cycle 20.
- Stub multiplier never asserts mul_done → err = 1 and busy = 0 after 32 WAIT cycles, no result_valid, outputs unchanged. The next req clears err.
- Assert reset at cycle 10 of an operation → all outputs 0 and state IDLE on the next cycle, with no result_valid. A fresh req then completes normally in 20 cycles.
